// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU.
// Ops 0-B (logic, add/sub, shifts, compare) produce a registered result one cycle after accept.
// Ops C-F (MUL, MULHU, DIVU, REMU) run iteratively, one bit per cycle, for WIDTH BUSY cycles.
// Build option: define ALU_SEQ_MULDIV_EN to include the multiply/divide datapath. Without it,
// ops C-F complete in one cycle with out=0 and err=1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high. in_ready
// depends only on state, flush and out_ready, never on in_valid. out/of/dz/err stay stable while
// out_valid=1 and out_ready=0. flush cancels everything, and in_valid is ignored in that cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic             dz,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_n;
  logic             of_n;
  logic             err_n;

  // Single-cycle result for the operation currently offered on the input port.
  always_comb begin
    sh    = in_1[SH_W-1:0];
    sum   = in_0 + in_1;
    diff  = in_0 - in_1;
    r_n   = '0;
    of_n  = 1'b0;
    err_n = 1'b0;
    case (op)
      4'h0: r_n = in_1;
      4'h1: r_n = in_0 & in_1;
      4'h2: r_n = in_0 | in_1;
      4'h3: r_n = in_0 ^ in_1;
      4'h4: begin
        r_n  = sum;
        of_n = (in_0[MSB] == in_1[MSB]) && (sum[MSB] != in_0[MSB]);
      end
      4'h5: r_n = sum;
      4'h6: begin
        r_n  = diff;
        of_n = (in_0[MSB] != in_1[MSB]) && (diff[MSB] != in_0[MSB]);
      end
      4'h7: r_n = diff;
      4'h8: r_n = in_0 >> sh;
      4'h9: r_n = $unsigned($signed(in_0) >>> sh);
      4'hA: r_n = in_0 << sh;
      4'hB: r_n = {{(WIDTH-1){1'b0}}, ($signed(in_0) < $signed(in_1))};
      default: begin
        // Multiply/divide: only reaches the result register when the datapath is absent.
        r_n   = '0;
`ifdef ALU_SEQ_MULDIV_EN
        err_n = 1'b0;
`else
        err_n = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  // md_acc: product high half / partial remainder. md_q: multiplier / dividend-then-quotient.
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_acc;
  logic [WIDTH-1:0] md_q;
  logic [1:0]       md_op;
  logic [SH_W-1:0]  cnt;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   dsh;
  logic [WIDTH:0]   dsub;
  logic [WIDTH-1:0] nacc;
  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] md_res;

  // One iteration: shift-add multiply (md_op[1]=0) or restoring divide (md_op[1]=1).
  always_comb begin
    madd = {1'b0, md_acc} + (md_q[0] ? {1'b0, md_a} : {(WIDTH+1){1'b0}});
    dsh  = {md_acc, md_q[MSB]};
    dsub = dsh - {1'b0, md_a};
    if (!md_op[1]) begin
      nacc = madd[WIDTH:1];
      nq   = {madd[0], md_q[MSB:1]};
    end else if (!dsub[WIDTH]) begin
      nacc = dsub[WIDTH-1:0];
      nq   = {md_q[MSB-1:0], 1'b1};
    end else begin
      nacc = dsh[WIDTH-1:0];
      nq   = {md_q[MSB-1:0], 1'b0};
    end
    // MUL/DIVU take the low/quotient word, MULHU/REMU the high/remainder word.
    md_res = md_op[0] ? nacc : nq;
  end
`endif

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      of        <= 1'b0;
      dz        <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      md_a      <= '0;
      md_acc    <= '0;
      md_q      <= '0;
      md_op     <= 2'b00;
      cnt       <= '0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (op[3:2] == 2'b11) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              md_a      <= in_1;
              md_acc    <= '0;
              md_q      <= in_0;
              md_op     <= op[1:0];
              cnt       <= SH_W'(WIDTH - 1);
            end else
`endif
            begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= r_n;
              of        <= of_n;
              dz        <= 1'b0;
              err       <= err_n;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          md_acc <= nacc;
          md_q   <= nq;
          cnt    <= cnt - SH_W'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= md_res;
            of        <= 1'b0;
            dz        <= md_op[1] && (md_a == '0);
            err       <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
